cte_arb: RTL and testbench
==========================

CTE_ARB -- requirements
Module: cte_arb

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 4: number of pixel pairs in flight inside CTE (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  sole clock; all flops on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester n offers one RGB pixel.
REQ-005 SHALL have ports req0_rgb/req1_rgb  input  24  pixel {R,G,B}.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  pixel accepted this cycle when valid&ready.
REQ-007 SHALL have ports rsp0_valid/rsp1_valid  output  1  YUV byte for requester n; no backpressure.
REQ-008 SHALL have ports rsp0_yuv/rsp1_yuv  output  8  byte, order U,Y0,V,Y1 per pair.
REQ-009 SHALL have ports rsp0_last/rsp1_last  output  1  marks 4th byte (Y1) of a pair.
REQ-010 SHALL have ports cte_op_mode  output  1; cte_in_en  output  1; cte_rgb_in  output  24: drive CTE.
REQ-011 SHALL have ports cte_busy  input  1; cte_out_valid  input  1; cte_yuv_out  input  8: from CTE.
REQ-012 SHALL have port err_orphan  output  1  sticky: CTE byte arrived with no owner tag.

Function
REQ-013 SHALL drive cte_op_mode constant 1 (RGB->YUV 4:2:2).
REQ-014 SHALL use FSM IDLE -> PIX0 -> PIX1 -> IDLE; grant unit is one pixel pair.
REQ-015 IDLE: if tag FIFO not full and any req valid, SHALL grant round-robin (last-granted loses ties), latch owner, push owner tag, go PIX0; else stay.
REQ-016 PIX0/PIX1: ready(owner) = !cte_busy; cte_in_en = owner valid & !cte_busy; cte_rgb_in = owner rgb, else 24'h0.
REQ-017 Non-owner ready SHALL be 0; no switching owner mid-pair; owner stall (valid=0) holds state indefinitely.
REQ-018 On accepted pixel: PIX0 -> PIX1, PIX1 -> IDLE.
REQ-019 Response: on cte_out_valid, byte SHALL route combinationally to FIFO-head owner's rsp port same cycle; 2-bit byte counter increments; at count 3 assert rsp_last, pop tag, counter wraps to 0.
REQ-020 Tag push and pop in same cycle SHALL both occur; FIFO full blocks grant only, never a pop.
REQ-021 cte_out_valid with FIFO empty SHALL set err_orphan, drop byte, leave counter unchanged.
REQ-022 Non-selected rsp port SHALL have valid=0, last=0, yuv=8'h00.

Reset
REQ-023 While reset=1: state IDLE, FIFO empty, byte counter 0, round-robin pointer favours req0, err_orphan 0.
REQ-024 Outputs during reset: all ready/valid/last/cte_in_en 0, cte_rgb_in 0, rsp_yuv 0, cte_op_mode 1.
REQ-025 Reset mid-pair SHALL discard partial pair and tags; requesters re-issue.

Configuration
REQ-026 With CTE_ARB_PRIO_EN defined, IDLE grant SHALL be fixed priority req0 over req1; undefined, round-robin per REQ-015.

Structure
REQ-027 Shared package cte_pkg SHALL hold FSM state enum, owner-tag type, byte-index constants (U=0,Y0=1,V=2,Y1=3).
REQ-028 Tag FIFO SHALL be sub-module cte_tag_fifo (1-bit data, TAG_DEPTH deep, push/pop/full/empty).

Verification
REQ-029 req0 only, 4 pixels, busy=0 -> grants pairs at cycles IDLE+1,+2; rsp0 gets 8 bytes, rsp0_last on bytes 4 and 8; rsp1 silent.
REQ-030 Both valid continuously, 8 pairs -> grants alternate 0,1,0,1...; with CTE_ARB_PRIO_EN all req0 until req0 drops.
REQ-031 cte_busy=1 for 5 cycles during PIX1 -> ready 0, state held, pixel 2 issued first cycle busy=0.
REQ-032 CTE stalls output after TAG_DEPTH=4 pairs issued -> no 5th grant until first rsp_last; then grant same cycle as pop allowed next IDLE.
REQ-033 cte_out_valid pulse after reset with no grant -> err_orphan=1, stays until reset.
REQ-034 Reset asserted in PIX1 -> next cycle all outputs per REQ-024, FIFO empty, first new grant goes to req0.

Source files
------------

// File: rtl/cte_pkg.sv
// Shared types and constants for the CTE arbiter: FSM states, owner tag, byte order.
package cte_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PIX0 = 2'd1,
    ST_PIX1 = 2'd2
  } state_t;

  typedef logic owner_t;

  localparam logic [1:0] BYTE_U  = 2'd0;
  localparam logic [1:0] BYTE_Y0 = 2'd1;
  localparam logic [1:0] BYTE_V  = 2'd2;
  localparam logic [1:0] BYTE_Y1 = 2'd3;

  // Round-robin choice: on a tie the requester granted last time loses.
  function automatic owner_t rr_pick(input logic v0, input logic v1, input owner_t last);
    if (v0 && v1) return ~last;
    else if (v1)  return 1'b1;
    else          return 1'b0;
  endfunction

endpackage

// File: rtl/cte_arb_if.sv
// Requester, response and CTE-side signals of the arbiter; master is the arbiter view.
interface cte_arb_if;
  logic        req0_valid;
  logic [23:0] req0_rgb;
  logic        req0_ready;
  logic        req1_valid;
  logic [23:0] req1_rgb;
  logic        req1_ready;
  logic        rsp0_valid;
  logic [7:0]  rsp0_yuv;
  logic        rsp0_last;
  logic        rsp1_valid;
  logic [7:0]  rsp1_yuv;
  logic        rsp1_last;
  logic        cte_op_mode;
  logic        cte_in_en;
  logic [23:0] cte_rgb_in;
  logic        cte_busy;
  logic        cte_out_valid;
  logic [7:0]  cte_yuv_out;
  logic        err_orphan;

  modport master (
    input  req0_valid, req0_rgb, req1_valid, req1_rgb,
    input  cte_busy, cte_out_valid, cte_yuv_out,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_yuv, rsp0_last,
    output rsp1_valid, rsp1_yuv, rsp1_last,
    output cte_op_mode, cte_in_en, cte_rgb_in, err_orphan
  );

  modport slave (
    output req0_valid, req0_rgb, req1_valid, req1_rgb,
    output cte_busy, cte_out_valid, cte_yuv_out,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_yuv, rsp0_last,
    input  rsp1_valid, rsp1_yuv, rsp1_last,
    input  cte_op_mode, cte_in_en, cte_rgb_in, err_orphan
  );
endinterface

// File: rtl/cte_tag_fifo.sv
// Owner-tag FIFO: 1-bit entries, DEPTH deep (power of two), simultaneous push/pop allowed.
module cte_tag_fifo import cte_pkg::*; #(
  parameter int unsigned DEPTH = 4
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  owner_t push_data,
  input  logic   pop,
  output owner_t pop_data,
  output logic   full,
  output logic   empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  owner_t [DEPTH-1:0] mem;
  logic   [AW-1:0]    wr_ptr;
  logic   [AW-1:0]    rd_ptr;
  logic   [AW:0]      count;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cte_arb.sv
// Two-requester arbiter in front of the CTE colour engine; grants whole pixel pairs.
// Define CTE_ARB_PRIO_EN for fixed req0-over-req1 priority instead of round-robin.
module cte_arb import cte_pkg::*; #(
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  cte_arb_if.master    bus
);

  state_t state_q, state_d;
  owner_t owner_q, owner_d;
  owner_t last_q, last_d;
  owner_t grant_sel;
  owner_t head;
  logic [1:0] cnt_q;
  logic       err_q;
  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic       own_valid, accept;
  logic [23:0] own_rgb;

  cte_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (grant_sel),
    .pop       (fifo_pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
`ifdef CTE_ARB_PRIO_EN
    grant_sel = bus.req0_valid ? 1'b0 : 1'b1;
`else
    grant_sel = rr_pick(bus.req0_valid, bus.req1_valid, last_q);
`endif
  end

  assign own_valid = owner_q ? bus.req1_valid : bus.req0_valid;
  assign own_rgb   = owner_q ? bus.req1_rgb   : bus.req0_rgb;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    fifo_push      = 1'b0;
    accept         = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.cte_in_en  = 1'b0;
    bus.cte_rgb_in = '0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_full && (bus.req0_valid || bus.req1_valid)) begin
          owner_d   = grant_sel;
          last_d    = grant_sel;
          fifo_push = 1'b1;
          state_d   = ST_PIX0;
        end
      end
      ST_PIX0, ST_PIX1: begin
        bus.req0_ready = !owner_q && !bus.cte_busy;
        bus.req1_ready =  owner_q && !bus.cte_busy;
        accept         = own_valid && !bus.cte_busy;
        bus.cte_in_en  = accept;
        bus.cte_rgb_in = accept ? own_rgb : '0;
        if (accept) state_d = (state_q == ST_PIX0) ? ST_PIX1 : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Response bytes bypass any register: they belong to the oldest outstanding pair.
  always_comb begin
    bus.rsp0_valid = 1'b0;
    bus.rsp0_yuv   = '0;
    bus.rsp0_last  = 1'b0;
    bus.rsp1_valid = 1'b0;
    bus.rsp1_yuv   = '0;
    bus.rsp1_last  = 1'b0;
    fifo_pop       = 1'b0;
    if (bus.cte_out_valid && !fifo_empty) begin
      fifo_pop = (cnt_q == BYTE_Y1);
      if (head) begin
        bus.rsp1_valid = 1'b1;
        bus.rsp1_yuv   = bus.cte_yuv_out;
        bus.rsp1_last  = (cnt_q == BYTE_Y1);
      end else begin
        bus.rsp0_valid = 1'b1;
        bus.rsp0_yuv   = bus.cte_yuv_out;
        bus.rsp0_last  = (cnt_q == BYTE_Y1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= BYTE_U;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      if (bus.cte_out_valid) begin
        if (fifo_empty) err_q <= 1'b1;
        else            cnt_q <= cnt_q + 2'd1;
      end
    end
  end

  assign bus.cte_op_mode = 1'b1;
  assign bus.err_orphan  = err_q;

endmodule

// File: tb/tb_cte_arb.sv
// Directed bench for cte_arb: pair grants, arbitration, stalls, tag-FIFO limit, orphan and reset.
module tb_cte_arb;
  import cte_pkg::*;

  localparam logic [23:0] RGB0 = 24'h112233;
  localparam logic [23:0] RGB1 = 24'hA5C3E7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned checks = 0;
  int unsigned failures = 0;

  cte_arb_if bus();

  cte_arb #(.TAG_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts in IDLE with the requesters already presenting; runs one full pair.
  task automatic do_pair(input logic own, input string tag);
    chk({tag, "_idle_rdy"}, {bus.req1_ready, bus.req0_ready}, 32'd0);
    tick();
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_rdy0"}, bus.req0_ready, !own);
      chk({tag, "_rdy1"}, bus.req1_ready, own);
      chk({tag, "_inen"}, bus.cte_in_en, 1'b1);
      chk({tag, "_rgb"},  bus.cte_rgb_in, own ? RGB1 : RGB0);
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic own, input logic last, input string tag);
    bus.cte_out_valid = 1'b1;
    bus.cte_yuv_out   = b;
    #1;
    chk({tag, "_v0"},   bus.rsp0_valid, !own);
    chk({tag, "_v1"},   bus.rsp1_valid, own);
    chk({tag, "_yuv0"}, bus.rsp0_yuv, own ? 8'h00 : b);
    chk({tag, "_yuv1"}, bus.rsp1_yuv, own ? b : 8'h00);
    chk({tag, "_last"}, {bus.rsp1_last, bus.rsp0_last}, last ? (own ? 32'd2 : 32'd1) : 32'd0);
    @(posedge clk);
    #1;
    bus.cte_out_valid = 1'b0;
    bus.cte_yuv_out   = 8'h00;
  endtask

  task automatic drain_pair(input logic own, input logic [7:0] base, input string tag);
    for (int i = 0; i < 4; i++)
      send_byte(base + 8'(i), own, i == 3, tag);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"},  {bus.req1_ready, bus.req0_ready}, 32'd0);
    chk({tag, "_inen"}, bus.cte_in_en, 1'b0);
    chk({tag, "_rgb"},  bus.cte_rgb_in, 24'h0);
    chk({tag, "_rspv"}, {bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_last, bus.rsp0_last}, 32'd0);
    chk({tag, "_yuv"},  {bus.rsp1_yuv, bus.rsp0_yuv}, 32'd0);
    chk({tag, "_mode"}, bus.cte_op_mode, 1'b1);
    chk({tag, "_err"},  bus.err_orphan, 1'b0);
  endtask

  logic own_seq [5];

  initial begin
    bus.req0_valid    = 1'b0;
    bus.req0_rgb      = RGB0;
    bus.req1_valid    = 1'b0;
    bus.req1_rgb      = RGB1;
    bus.cte_busy      = 1'b0;
    bus.cte_out_valid = 1'b0;
    bus.cte_yuv_out   = 8'h00;

    // Reset state
    #2;
    chk_reset_outputs("rst");
    tick();
    tick();
    reset = 1'b0;
    #1;

    // req0 alone: two pairs, eight bytes to rsp0 only
    bus.req0_valid = 1'b1;
    #1;
    do_pair(1'b0, "a_p1");
    do_pair(1'b0, "a_p2");
    bus.req0_valid = 1'b0;
    #1;
    drain_pair(1'b0, 8'h10, "a_b1");
    drain_pair(1'b0, 8'h14, "a_b2");

    // Both requesters: four pairs fill the tag FIFO
`ifdef CTE_ARB_PRIO_EN
    for (int i = 0; i < 5; i++) own_seq[i] = 1'b0;
`else
    own_seq[0] = 1'b1; own_seq[1] = 1'b0; own_seq[2] = 1'b1;
    own_seq[3] = 1'b0; own_seq[4] = 1'b1;
`endif
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) do_pair(own_seq[i], "b_pair");
    for (int i = 0; i < 3; i++) begin
      chk("b_full_hold", {bus.req1_ready, bus.req0_ready, bus.cte_in_en}, 32'd0);
      tick();
    end
    drain_pair(own_seq[0], 8'h40, "b_d0");
    chk("b_pop_nogrant", {bus.req1_ready, bus.req0_ready}, 32'd0);
    do_pair(own_seq[4], "b_p5");
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    for (int i = 1; i < 5; i++) drain_pair(own_seq[i], 8'h50 + 8'(i * 4), "b_dn");

    // CTE busy for five cycles in PIX1
    bus.req0_valid = 1'b1;
    #1;
    tick();
    chk("c_pix0_inen", bus.cte_in_en, 1'b1);
    tick();
    bus.cte_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("c_busy_rdy", bus.req0_ready, 1'b0);
      chk("c_busy_inen", bus.cte_in_en, 1'b0);
      tick();
    end
    bus.cte_busy = 1'b0;
    #1;
    chk("c_resume_rdy", bus.req0_ready, 1'b1);
    chk("c_resume_rgb", bus.cte_rgb_in, RGB0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    tick();
    chk("c_back_idle", {bus.req0_ready, bus.cte_in_en}, 32'd0);

    // req1 alone into PIX1, then reset mid-pair
    bus.req1_valid = 1'b1;
    #1;
    tick();
    chk("d_pix0_rdy1", bus.req1_ready, 1'b1);
    tick();
    chk("d_pix1_inen", bus.cte_in_en, 1'b1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("d_rst");
    bus.req1_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;

    // Orphan byte: FIFO empty after reset, byte dropped, sticky error
    bus.cte_out_valid = 1'b1;
    bus.cte_yuv_out   = 8'h77;
    #1;
    chk("e_orph_rsp", {bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    chk("e_orph_err0", bus.err_orphan, 1'b0);
    tick();
    bus.cte_out_valid = 1'b0;
    #1;
    chk("e_orph_err1", bus.err_orphan, 1'b1);

    // First grant after reset favours req0
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    tick();
    chk("e_grant_rdy0", bus.req0_ready, 1'b1);
    chk("e_grant_rdy1", bus.req1_ready, 1'b0);
    tick();
    tick();
    chk("e_err_sticky", bus.err_orphan, 1'b1);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("e_err_cleared", bus.err_orphan, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
